// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the shared memory port arbiter: per-requester
// request/strobe/address/data lanes in, single memory port and grant status out.
interface mem_port_arbiter_if #(
  parameter int P      = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 96
);
  logic [P-1:0]        in_request;
  logic [P*ADDR_W-1:0] in_address;
  logic [P*DATA_W-1:0] in_wdata;
  logic [P-1:0]        in_read_en;
  logic [P-1:0]        in_write_en;
  logic [P-1:0]        out_grant;
  logic [ADDR_W-1:0]   out_mem_address;
  logic [DATA_W-1:0]   out_mem_data;
  logic                out_mem_read_en;
  logic                out_mem_write_en;
  logic [P-1:0]        out_rdata_valid;
  logic                out_busy;

  modport slave (
    input  in_request, in_address, in_wdata, in_read_en, in_write_en,
    output out_grant, out_mem_address, out_mem_data, out_mem_read_en,
           out_mem_write_en, out_rdata_valid, out_busy
  );

  modport master (
    output in_request, in_address, in_wdata, in_read_en, in_write_en,
    input  out_grant, out_mem_address, out_mem_data, out_mem_read_en,
           out_mem_write_en, out_rdata_valid, out_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among P requesters.
// A grant lasts until the owner releases its request or MAX_BURST strobes
// have been forwarded; outstanding reads are then drained so that every
// read-data return is tagged with the requester that issued it.
module mem_port_arbiter #(
  parameter int P         = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 96,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input logic               in_clk,
  input logic               in_reset,
  mem_port_arbiter_if.slave bus
);
  localparam int ID_W   = (P > 1) ? $clog2(P) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [P-1:0]                 grant_q, grant_d;
  logic [ID_W-1:0]              owner_q, owner_d;
  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic [RD_LAT-1:0]            rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0][ID_W-1:0]  rd_id_q, rd_id_d;

  logic            fwd_rd;
  logic            fwd_wr;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  int              cand;

  // Forward the owner's lane to the memory port; a simultaneous write wins over the read.
  always_comb begin
    fwd_rd               = 1'b0;
    fwd_wr               = 1'b0;
    bus.out_mem_address  = '0;
    bus.out_mem_data     = '0;
    if (state_q == GRANT) begin
      fwd_wr              = bus.in_write_en[owner_q];
      fwd_rd              = bus.in_read_en[owner_q] & ~bus.in_write_en[owner_q];
      bus.out_mem_address = bus.in_address[int'(owner_q)*ADDR_W +: ADDR_W];
      bus.out_mem_data    = bus.in_wdata[int'(owner_q)*DATA_W +: DATA_W];
    end
    bus.out_mem_read_en  = fwd_rd;
    bus.out_mem_write_en = fwd_wr;
  end

  // Round-robin search: first requester at or after ptr+1, wrapping modulo P.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= P; k++) begin
      cand = (int'(ptr_q) + k) % P;
      if (!pick_found && bus.in_request[cand]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(cand);
      end
    end
  end

  // Next-state logic for the grant FSM, burst counter and priority pointer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d           = GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          ptr_d             = pick_idx;
          beat_d            = '0;
        end
      end
      GRANT: begin
        if (fwd_rd || fwd_wr) beat_d = beat_q + 1'b1;
        // Released request or the burst cap reached on this beat ends the grant.
        if (!bus.in_request[owner_q] ||
            ((fwd_rd || fwd_wr) && (beat_q == BEAT_W'(MAX_BURST - 1)))) begin
          state_d = DRAIN;
          grant_d = '0;
        end
      end
      DRAIN: begin
        if (rd_vld_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-return tracker: each forwarded read enters at stage 0 tagged with its owner.
  always_comb begin
    rd_vld_d[0] = fwd_rd;
    rd_id_d[0]  = owner_q;
    for (int s = 1; s < RD_LAT; s++) begin
      rd_vld_d[s] = rd_vld_q[s-1];
      rd_id_d[s]  = rd_id_q[s-1];
    end
  end

  // Control state; reset discards any in-flight read tracking.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= ID_W'(P - 1);
      beat_q   <= '0;
      rd_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Owner tags only matter when their valid bit is set, so they need no reset.
  always_ff @(posedge in_clk) begin
    rd_id_q <= rd_id_d;
  end

  // One-hot read-data owner from the last tracker stage.
  always_comb begin
    bus.out_rdata_valid = '0;
    if (rd_vld_q[RD_LAT-1]) bus.out_rdata_valid[rd_id_q[RD_LAT-1]] = 1'b1;
  end

  assign bus.out_grant = grant_q;
  assign bus.out_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table covering
// round-robin order, forwarding, write-over-read and drain timing, plus
// hand-written sequences for the burst cap and reset mid-read.
module tb_mem_port_arbiter;
  localparam int P         = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 96;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 16;
  localparam int NONE      = 4;
  localparam int NV        = 31;

  logic in_clk   = 1'b0;
  logic in_reset = 1'b0;

  mem_port_arbiter_if #(.P(P), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .P(P), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .in_clk  (in_clk),
    .in_reset(in_reset),
    .bus     (bus.slave)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [3:0] grant;
    logic       busy;
    logic       mrd;
    logic       mwr;
    int         own;
    logic [3:0] rv;
  } vec_t;

  vec_t vec [NV];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [ADDR_W-1:0] addr_of(int i);
    return ADDR_W'(10'h120 + i * 37);
  endfunction

  function automatic logic [DATA_W-1:0] data_of(int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {w, ~w, w};
  endfunction

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " grant"},    bus.out_grant, 0);
    chk({tag, " busy"},     bus.out_busy, 0);
    chk({tag, " mem_rd"},   bus.out_mem_read_en, 0);
    chk({tag, " mem_wr"},   bus.out_mem_write_en, 0);
    chk({tag, " mem_addr"}, bus.out_mem_address, 0);
    chk({tag, " mem_data"}, bus.out_mem_data, 0);
    chk({tag, " rvalid"},   bus.out_rdata_valid, 0);
  endtask

  initial begin
    int reads, pulses, seg, nseg, cyc, t;
    int segs [4];
    int rq [$];
    logic prev_g, done;

    // req, rd, wr | grant, busy, mrd, mwr, owner, rdata_valid
    vec[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};
    vec[1]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 0,    4'b0000};
    vec[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0000};
    vec[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};
    vec[4]  = '{4'b1101, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1,    4'b0000};
    vec[5]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0000};
    vec[6]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};
    vec[7]  = '{4'b1011, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 2,    4'b0000};
    vec[8]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0000};
    vec[9]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};
    vec[10] = '{4'b0111, 4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 3,    4'b0000};
    vec[11] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0000};
    vec[12] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};
    vec[13] = '{4'b1110, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 0,    4'b0000};
    vec[14] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0000};
    vec[15] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};
    vec[16] = '{4'b0010, 4'b0010, 4'b1010, 4'b0010, 1'b1, 1'b0, 1'b1, 1,    4'b0000};
    vec[17] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1,    4'b0000};
    vec[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1,    4'b0000};
    vec[19] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0000};
    vec[20] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};
    vec[21] = '{4'b0001, 4'b0001, 4'b1000, 4'b0001, 1'b1, 1'b1, 1'b0, 0,    4'b0000};
    vec[22] = '{4'b0001, 4'b0000, 4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0, 0,    4'b0000};
    vec[23] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 0,    4'b0001};
    vec[24] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0000};
    vec[25] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};
    vec[26] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 2,    4'b0000};
    vec[27] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 2,    4'b0000};
    vec[28] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0100};
    vec[29] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, NONE, 4'b0000};
    vec[30] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, NONE, 4'b0000};

    bus.in_request  = '0;
    bus.in_read_en  = '0;
    bus.in_write_en = '0;
    for (int i = 0; i < P; i++) begin
      bus.in_address[i*ADDR_W +: ADDR_W] = addr_of(i);
      bus.in_wdata[i*DATA_W +: DATA_W]   = data_of(i);
    end

    // Reset state, then release on a falling edge.
    repeat (2) @(negedge in_clk);
    #2;
    chk_all_zero("reset");
    @(negedge in_clk);
    in_reset = 1'b1;

    // Table: inputs applied on the falling edge, outputs sampled 2 units later.
    for (int r = 0; r < NV; r++) begin
      bus.in_request  = vec[r].req;
      bus.in_read_en  = vec[r].rd;
      bus.in_write_en = vec[r].wr;
      #2;
      chk($sformatf("row%0d grant", r),  bus.out_grant, vec[r].grant);
      chk($sformatf("row%0d busy", r),   bus.out_busy, vec[r].busy);
      chk($sformatf("row%0d mem_rd", r), bus.out_mem_read_en, vec[r].mrd);
      chk($sformatf("row%0d mem_wr", r), bus.out_mem_write_en, vec[r].mwr);
      chk($sformatf("row%0d mem_addr", r), bus.out_mem_address,
          (vec[r].own == NONE) ? '0 : addr_of(vec[r].own));
      chk($sformatf("row%0d mem_data", r), bus.out_mem_data,
          (vec[r].own == NONE) ? '0 : data_of(vec[r].own));
      chk($sformatf("row%0d rvalid", r), bus.out_rdata_valid, vec[r].rv);
      @(negedge in_clk);
    end

    // Requester 2 alone issues 20 reads: capped at MAX_BURST, then re-granted.
    reads = 0; pulses = 0; seg = 0; nseg = 0; cyc = 0;
    prev_g = 1'b0; done = 1'b0;
    while (!done && cyc < 300) begin
      bus.in_request = (reads < 20) ? 4'b0100 : 4'b0000;
      bus.in_read_en = (bus.out_grant[2] && reads < 20) ? 4'b0100 : 4'b0000;
      #2;
      if (bus.out_mem_read_en) begin
        rq.push_back(cyc);
        reads++;
        seg++;
      end
      if (bus.out_rdata_valid != '0) begin
        chk("burst rvalid owner", bus.out_rdata_valid, 4'b0100);
        if (rq.size() == 0) begin
          chk("burst rvalid without read", 1, 0);
        end else begin
          t = rq.pop_front();
          chk("burst rvalid latency", cyc - t, RD_LAT);
          pulses++;
        end
      end
      if (bus.out_grant != '0) chk("burst grant owner", bus.out_grant, 4'b0100);
      if (prev_g && bus.out_grant == '0) begin
        if (nseg < 4) segs[nseg] = seg;
        nseg++;
        seg = 0;
      end
      prev_g = bus.out_grant[2];
      if (reads == 20 && rq.size() == 0 && !bus.out_busy) done = 1'b1;
      cyc++;
      @(negedge in_clk);
    end
    chk("burst completes in budget", done, 1);
    chk("burst grant count", nseg, 2);
    if (nseg >= 2) begin
      chk("burst first grant beats", segs[0], MAX_BURST);
      chk("burst second grant beats", segs[1], 20 - MAX_BURST);
    end
    chk("burst reads forwarded", reads, 20);
    chk("burst rvalid pulses", pulses, 20);

    // Reset asserted one cycle after a read: outputs clear at once, no late rvalid.
    bus.in_request = 4'b0001;
    bus.in_read_en = 4'b0000;
    @(negedge in_clk);
    #2;
    chk("rst grant before read", bus.out_grant, 4'b0001);
    @(negedge in_clk);
    bus.in_read_en = 4'b0001;
    #2;
    chk("rst read forwarded", bus.out_mem_read_en, 1);
    @(negedge in_clk);
    #1;
    in_reset = 1'b0;
    #1;
    chk_all_zero("rst asserted");
    @(posedge in_clk);
    #2;
    chk_all_zero("rst held");
    @(negedge in_clk);
    bus.in_request = '0;
    bus.in_read_en = '0;
    in_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("post-rst rvalid c%0d", c), bus.out_rdata_valid, 0);
      chk($sformatf("post-rst busy c%0d", c), bus.out_busy, 0);
      @(negedge in_clk);
    end

    // Pointer back at P-1: requester 0 beats requester 1.
    bus.in_request = 4'b0011;
    #2;
    chk("post-rst idle grant", bus.out_grant, 0);
    @(negedge in_clk);
    #2;
    chk("post-rst first winner", bus.out_grant, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
